// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind scoring path.
// Covers colour width, slot count, peg encodings and the scorer FSM states.
package mastermind_pkg;

    localparam int COLOR_W       = 3;
    localparam int NUM_SLOTS     = 4;
    localparam int CNT_W         = 3;
    localparam int SCORE_LATENCY = 22;

    typedef logic [1:0] peg_t;

    localparam peg_t PEG_NONE    = 2'd0;
    localparam peg_t PEG_PARTIAL = 2'd1;
    localparam peg_t PEG_EXACT   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_EXACT,
        S_PARTIAL,
        S_REPORT
    } state_t;

endpackage

// File: rtl/peg_sorter.sv
// Turns exact/partial counts into four sorted pegs.
// Exact pegs come first, then partial pegs, then blanks.
module peg_sorter
    import mastermind_pkg::*;
(
    input  logic [CNT_W-1:0] exact,
    input  logic [CNT_W-1:0] partial,
    output peg_t             pegs [NUM_SLOTS]
);

    localparam int SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] total;

    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        total = {1'b0, exact} + {1'b0, partial};
        for (int k = 0; k < NUM_SLOTS; k++) begin
            pegs[k] = PEG_NONE;
            if (SUM_W'(k) < {1'b0, exact}) begin
                pegs[k] = PEG_EXACT;
            end else if (SUM_W'(k) < total) begin
                pegs[k] = PEG_PARTIAL;
            end
        end
    end

endmodule

// File: rtl/peg_scorer.sv
// Fixed-latency Mastermind scorer: one latch cycle, four exact cycles,
// sixteen partial cycles and one report cycle per evaluation.
module peg_scorer #(
    parameter int COLOR_W = mastermind_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               clear,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    output logic               busy,
    output logic               done,
    output logic [2:0]         exact_cnt,
    output logic [2:0]         partial_cnt,
    output logic [1:0]         peg0,
    output logic [1:0]         peg1,
    output logic [1:0]         peg2,
    output logic [1:0]         peg3,
    output logic               game_over
);

    import mastermind_pkg::*;

    state_t state, state_n;

    logic [COLOR_W-1:0]   code_in  [NUM_SLOTS];
    logic [COLOR_W-1:0]   guess_in [NUM_SLOTS];
    logic [COLOR_W-1:0]   code_q   [NUM_SLOTS];
    logic [COLOR_W-1:0]   guess_q  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] code_used;
    logic [NUM_SLOTS-1:0] guess_used;
    logic [CNT_W-1:0]     exact_q;
    logic [CNT_W-1:0]     partial_q;
    logic [3:0]           step;
    logic [1:0]           gi;
    logic [1:0]           cj;
    peg_t                 pegs_next [NUM_SLOTS];

    assign code_in  = '{code0, code1, code2, code3};
    assign guess_in = '{guess0, guess1, guess2, guess3};

    // Partial pass walks guess slot gi (outer) against code slot cj (inner).
    assign gi = step[3:2];
    assign cj = step[1:0];

    peg_sorter u_sorter (
        .exact   (exact_q),
        .partial (partial_q),
        .pegs    (pegs_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_LATCH;
            end
            S_LATCH: begin
                busy    = 1'b1;
                state_n = S_EXACT;
            end
            S_EXACT: begin
                busy = 1'b1;
                if (cj == 2'd3) state_n = S_PARTIAL;
            end
            S_PARTIAL: begin
                busy = 1'b1;
                if (step == 4'hF) state_n = S_REPORT;
            end
            S_REPORT: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, and the small operand arrays are reset explicitly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                code_q[k]  <= '0;
                guess_q[k] <= '0;
            end
            code_used   <= '0;
            guess_used  <= '0;
            exact_q     <= '0;
            partial_q   <= '0;
            step        <= '0;
            exact_cnt   <= '0;
            partial_cnt <= '0;
            peg0        <= PEG_NONE;
            peg1        <= PEG_NONE;
            peg2        <= PEG_NONE;
            peg3        <= PEG_NONE;
            game_over   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear && !start) begin
                        exact_cnt   <= '0;
                        partial_cnt <= '0;
                        peg0        <= PEG_NONE;
                        peg1        <= PEG_NONE;
                        peg2        <= PEG_NONE;
                        peg3        <= PEG_NONE;
                        game_over   <= 1'b0;
                    end
                end
                S_LATCH: begin
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        code_q[k]  <= code_in[k];
                        guess_q[k] <= guess_in[k];
                    end
                    code_used  <= '0;
                    guess_used <= '0;
                    exact_q    <= '0;
                    partial_q  <= '0;
                    step       <= '0;
                end
                S_EXACT: begin
                    if (guess_q[cj] == code_q[cj]) begin
                        exact_q        <= exact_q + 3'd1;
                        code_used[cj]  <= 1'b1;
                        guess_used[cj] <= 1'b1;
                    end
                    step <= (cj == 2'd3) ? 4'd0 : step + 4'd1;
                end
                S_PARTIAL: begin
                    if (!guess_used[gi] && !code_used[cj] && guess_q[gi] == code_q[cj]) begin
                        partial_q      <= partial_q + 3'd1;
                        code_used[cj]  <= 1'b1;
                        guess_used[gi] <= 1'b1;
                    end
                    step <= step + 4'd1;
                end
                S_REPORT: begin
                    exact_cnt   <= exact_q;
                    partial_cnt <= partial_q;
                    peg0        <= pegs_next[0];
                    peg1        <= pegs_next[1];
                    peg2        <= pegs_next[2];
                    peg3        <= pegs_next[3];
                    if (exact_q == 3'(NUM_SLOTS)) game_over <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    a_count_sum: assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, exact_q} + {1'b0, partial_q}) <= 4'd4);

    a_peg_legal: assert property (@(posedge clk) disable iff (!reset_n)
        (peg0 != 2'd3) && (peg1 != 2'd3) && (peg2 != 2'd3) && (peg3 != 2'd3));

endmodule

// File: tb/tb_peg_scorer.sv
// Scoreboard bench for peg_scorer: expected scores come from a colour-count
// model, are queued at start and compared once the result is visible.
module tb_peg_scorer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       clear;
    logic [2:0] code0, code1, code2, code3;
    logic [2:0] guess0, guess1, guess2, guess3;
    logic       busy;
    logic       done;
    logic [2:0] exact_cnt;
    logic [2:0] partial_cnt;
    logic [1:0] peg0, peg1, peg2, peg3;
    logic       game_over;

    typedef struct packed {
        logic [2:0] e;
        logic [2:0] p;
        logic [7:0] pegs;
        logic       go;
    } exp_t;

    exp_t sb[$];
    logic exp_go;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    peg_scorer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .clear       (clear),
        .code0       (code0),
        .code1       (code1),
        .code2       (code2),
        .code3       (code3),
        .guess0      (guess0),
        .guess1      (guess1),
        .guess2      (guess2),
        .guess3      (guess3),
        .busy        (busy),
        .done        (done),
        .exact_cnt   (exact_cnt),
        .partial_cnt (partial_cnt),
        .peg0        (peg0),
        .peg1        (peg1),
        .peg2        (peg2),
        .peg3        (peg3),
        .game_over   (game_over)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Score = per-slot equality for exact; sum of per-colour minimum counts for total.
    function automatic exp_t model(input logic [11:0] c, input logic [11:0] g, input logic go_in);
        exp_t r;
        int   e;
        int   t;
        int   cc[8];
        int   gc[8];
        e = 0;
        t = 0;
        for (int k = 0; k < 8; k++) begin
            cc[k] = 0;
            gc[k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (c[3*i +: 3] == g[3*i +: 3]) e++;
            cc[c[3*i +: 3]]++;
            gc[g[3*i +: 3]]++;
        end
        for (int k = 0; k < 8; k++) t += (cc[k] < gc[k]) ? cc[k] : gc[k];
        r.e = 3'(e);
        r.p = 3'(t - e);
        for (int k = 0; k < 4; k++) begin
            if (k < e)      r.pegs[2*k +: 2] = 2'd2;
            else if (k < t) r.pegs[2*k +: 2] = 2'd1;
            else            r.pegs[2*k +: 2] = 2'd0;
        end
        r.go = go_in | (e == 4);
        return r;
    endfunction

    task automatic drive_ops(input logic [11:0] c, input logic [11:0] g);
        code0  = c[2:0];  code1  = c[5:3];  code2  = c[8:6];  code3  = c[11:9];
        guess0 = g[2:0];  guess1 = g[5:3];  guess2 = g[8:6];  guess3 = g[11:9];
    endtask

    task automatic check_outputs(input string tag, input exp_t x);
        check({tag, "_exact"},   exact_cnt, x.e);
        check({tag, "_partial"}, partial_cnt, x.p);
        check({tag, "_pegs"},    {peg3, peg2, peg1, peg0}, x.pegs);
        check({tag, "_go"},      game_over, x.go);
    endtask

    task automatic run_eval(input string name, input logic [11:0] c, input logic [11:0] g,
                            input bit with_clear, input bit disturb);
        exp_t x;
        int   n;
        bit   busy_ok;
        @(negedge clk);
        drive_ops(c, g);
        start = 1'b1;
        clear = with_clear;
        x = model(c, g, exp_go);
        sb.push_back(x);
        exp_go = x.go;
        @(negedge clk);
        start   = 1'b0;
        clear   = 1'b0;
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (disturb && n == 3) drive_ops(c, ~g);
            if (disturb && n == 5) start = 1'b1;
            if (disturb && n == 6) start = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!busy) busy_ok = 1'b0;
        check({name, "_latency"}, n, 22);
        check({name, "_busy_span"}, busy_ok, 1);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_after"}, busy, 0);
        x = sb.pop_front();
        check_outputs(name, x);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t zero_exp;
        int   dcnt;
        zero_exp = '0;
        reset_n  = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        exp_go   = 1'b0;
        drive_ops('0, '0);
        repeat (2) @(negedge clk);
        check_outputs("reset", zero_exp);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset_n = 1'b1;

        run_eval("win", pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 1'b0, 1'b0);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        exp_go = 1'b0;
        check_outputs("clear", zero_exp);

        run_eval("two_two", pack4(1, 1, 2, 2), pack4(1, 2, 1, 2), 1'b0, 1'b0);
        run_eval("dup",     pack4(0, 1, 2, 3), pack4(0, 0, 0, 0), 1'b0, 1'b0);
        run_eval("swap",    pack4(5, 5, 6, 6), pack4(6, 6, 5, 5), 1'b0, 1'b0);
        run_eval("disturb", pack4(1, 2, 3, 4), pack4(2, 1, 3, 4), 1'b0, 1'b1);
        count_done(25, dcnt);
        check("disturb_no_second_done", dcnt, 0);

        @(negedge clk);
        drive_ops(pack4(4, 4, 4, 4), pack4(4, 4, 4, 4));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        exp_go = 1'b0;
        check_outputs("abort", zero_exp);
        check("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_done(30, dcnt);
        check("abort_no_done", dcnt, 0);
        check("abort_exact_hold", exact_cnt, 0);

        run_eval("post_reset",  pack4(7, 6, 5, 4), pack4(4, 5, 6, 7), 1'b0, 1'b0);
        run_eval("start_clear", pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
